// File: rtl/serial_to_parallel_rx_pkg.sv
// Shared symbols and lock-state encoding for the lane receiver.
// Optional loss-of-sync detection is enabled by RX_LOS_DETECT_EN.
`ifndef SERIAL_TO_PARALLEL_RX_PKG_SV
`define SERIAL_TO_PARALLEL_RX_PKG_SV
package serial_to_parallel_rx_pkg;

  localparam logic [7:0] COM_SYM  = 8'hBC;
  localparam logic [7:0] IDLE_SYM = 8'h7C;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } rx_state_t;

endpackage
`endif

// File: rtl/rx_lock_fsm.sv
// Lane lock FSM: COM alignment counting and (with RX_LOS_DETECT_EN)
// loss-of-sync supervision while ACTIVE.
module rx_lock_fsm
  import serial_to_parallel_rx_pkg::*;
#(
  parameter int BC_LOCK = 4
`ifdef RX_LOS_DETECT_EN
  ,
  parameter int LOS_LIMIT = 32
`endif
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      i_boundary,
  input  logic      i_is_com,
  output rx_state_t o_state,
  output logic      o_active,
  output logic      o_sync_lost,
  output logic      o_los_hit
);

  localparam logic [3:0] LOCK = 4'(BC_LOCK);

  rx_state_t  r_state;
  rx_state_t  w_next;
  logic [3:0] r_bc_cnt;
  logic [3:0] w_bc_next;
  logic       r_active;
  logic       r_sync_lost;
  logic       w_los_hit;

`ifdef RX_LOS_DETECT_EN
  localparam logic [5:0] LOS = 6'(LOS_LIMIT);
  logic [5:0] r_los_cnt;
  logic [5:0] w_los_next;
`endif

  always_comb begin
    w_next    = r_state;
    w_bc_next = r_bc_cnt;
    w_los_hit = 1'b0;
`ifdef RX_LOS_DETECT_EN
    w_los_next = r_los_cnt;
`endif
    unique case (r_state)
      SEARCH: begin
        if (i_is_com) begin
          w_bc_next = 4'd1;
          w_next    = (LOCK == 4'd1) ? ACTIVE : ALIGN;
`ifdef RX_LOS_DETECT_EN
          w_los_next = '0;
`endif
        end
      end
      ALIGN: begin
        if (i_boundary) begin
          if (i_is_com) begin
            w_bc_next = (r_bc_cnt >= LOCK) ? LOCK
                                           : r_bc_cnt + 4'd1;
            if (r_bc_cnt + 4'd1 == LOCK)
              w_next = ACTIVE;
          end else begin
            w_next    = SEARCH;
            w_bc_next = '0;
          end
        end
      end
      ACTIVE: begin
`ifdef RX_LOS_DETECT_EN
        // COM on the limit boundary clears the count and wins
        if (i_boundary) begin
          if (i_is_com) begin
            w_los_next = '0;
          end else if (r_los_cnt + 6'd1 == LOS) begin
            w_los_hit  = 1'b1;
            w_next     = SEARCH;
            w_bc_next  = '0;
            w_los_next = '0;
          end else begin
            w_los_next = r_los_cnt + 6'd1;
          end
        end
`endif
      end
      default: begin
        w_next    = SEARCH;
        w_bc_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= SEARCH;
      r_bc_cnt    <= '0;
      r_active    <= 1'b0;
      r_sync_lost <= 1'b0;
`ifdef RX_LOS_DETECT_EN
      r_los_cnt   <= '0;
`endif
    end else begin
      r_state     <= w_next;
      r_bc_cnt    <= w_bc_next;
      r_active    <= (w_next == ACTIVE);
      r_sync_lost <= w_los_hit;
`ifdef RX_LOS_DETECT_EN
      r_los_cnt   <= w_los_next;
`endif
    end
  end

  assign o_state     = r_state;
  assign o_active    = r_active;
  assign o_sync_lost = r_sync_lost;
  assign o_los_hit   = w_los_hit;

endmodule

// File: rtl/serial_to_parallel_rx.sv
// Serial lane receiver: COM alignment, lock, and byte deserialization.
// Optional loss-of-sync detection is enabled by RX_LOS_DETECT_EN.
module serial_to_parallel_rx
  import serial_to_parallel_rx_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter logic [DATA_SIZE-1:0] COM  = DATA_SIZE'(COM_SYM),
  parameter logic [DATA_SIZE-1:0] IDLE = DATA_SIZE'(IDLE_SYM),
  parameter int BC_LOCK = 4
`ifdef RX_LOS_DETECT_EN
  ,
  parameter int LOS_LIMIT = 32
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 data_in,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 valid_out,
  output logic                 byte_stb,
  output logic                 active,
  output logic                 sync_lost
);

  // Only the newest DATA_SIZE-1 bits are needed; data_in completes the symbol
  logic [DATA_SIZE-2:0] r_sr;
  logic [2:0]           r_bit_cnt;
  logic [DATA_SIZE-1:0] r_data;
  logic                 r_valid;
  logic                 r_stb;

  logic [DATA_SIZE-1:0] w_cand;
  logic                 w_is_com;
  logic                 w_is_idle;
  logic                 w_boundary;
  logic                 w_realign;
  logic                 w_fwd;
  logic                 w_los_hit;
  rx_state_t            w_state;

  assign w_cand     = {r_sr, data_in};
  assign w_is_com   = (w_cand == COM);
  assign w_is_idle  = (w_cand == IDLE);
  assign w_boundary = (r_bit_cnt == 3'd7) && (w_state != SEARCH);
  assign w_realign  = (w_state == SEARCH) && w_is_com;
  assign w_fwd      = (w_state == ACTIVE) && !w_is_com
                   && !w_is_idle && !w_los_hit;

  rx_lock_fsm #(
    .BC_LOCK   (BC_LOCK)
`ifdef RX_LOS_DETECT_EN
    ,
    .LOS_LIMIT (LOS_LIMIT)
`endif
  ) u_lock (
    .clk         (clk),
    .reset       (reset),
    .i_boundary  (w_boundary),
    .i_is_com    (w_is_com),
    .o_state     (w_state),
    .o_active    (active),
    .o_sync_lost (sync_lost),
    .o_los_hit   (w_los_hit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sr      <= '0;
      r_bit_cnt <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_stb     <= 1'b0;
    end else begin
      r_sr      <= w_cand[DATA_SIZE-2:0];
      r_bit_cnt <= w_realign ? 3'd0 : r_bit_cnt + 3'd1;
      r_stb     <= w_boundary;
      if (w_boundary) begin
        if (w_fwd) begin
          r_data  <= w_cand;
          r_valid <= 1'b1;
        end else begin
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign byte_stb  = r_stb;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Directed bench for serial_to_parallel_rx (define RX_LOS_DETECT_EN
// to exercise loss-of-sync detection).
module tb_serial_to_parallel_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_stb;
  logic       active;
  logic       sync_lost;

  int errors = 0;
  int checks = 0;

  serial_to_parallel_rx dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .byte_stb  (byte_stb),
    .active    (active),
    .sync_lost (sync_lost)
  );

  always #5 clk = ~clk;

  task automatic send_bit(input logic b);
    @(negedge clk);
    data_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic lock4(input string tag);
    for (int k = 0; k < 4; k++) begin
      send_byte(8'hBC);
      checks++;
      if (active !== (k == 3)) begin
        errors++;
        $display("FAIL %s_active_bc%0d: got %b want %b",
                 tag, k, active, (k == 3));
      end
    end
  endtask

  task automatic test_reset();
    int stb_seen;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      data_in = ~data_in;
    end
    #1;
    checks++;
    if ({data_out, valid_out, byte_stb, active, sync_lost} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got %h/%b/%b/%b/%b want all 0",
               data_out, valid_out, byte_stb, active, sync_lost);
    end
    @(negedge clk);
    data_in = 1'b0;
    reset = 1'b1;
    stb_seen = 0;
    for (int i = 0; i < 16; i++) begin
      send_bit(1'b0);
      if (byte_stb) stb_seen++;
    end
    checks++;
    if (stb_seen != 0 || active !== 1'b0) begin
      errors++;
      $display("FAIL reset_search: stb=%0d active=%b want 0/0",
               stb_seen, active);
    end
  endtask

  task automatic test_lock();
    logic [7:0] bc;
    int v_seen;
    bc = 8'hBC;
    v_seen = 0;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    for (int k = 0; k < 4; k++) begin
      for (int i = 7; i >= 0; i--) begin
        send_bit(bc[i]);
        if (valid_out) v_seen++;
        if (k == 3 && i == 1) begin
          checks++;
          if (active !== 1'b0) begin
            errors++;
            $display("FAIL lock_early: active=%b want 0", active);
          end
        end
      end
    end
    checks++;
    if (active !== 1'b1) begin
      errors++;
      $display("FAIL lock_active: got %b want 1", active);
    end
    checks++;
    if (v_seen != 0) begin
      errors++;
      $display("FAIL lock_valid: valid seen %0d want 0", v_seen);
    end
  endtask

  task automatic test_data();
    logic [7:0] sym [4];
    logic       ev  [4];
    logic [7:0] ed  [4];
    logic [7:0] cur;
    logic       pv;
    logic [7:0] pd;
    int         bad;
    sym = '{8'hBC, 8'h7C, 8'hA5, 8'h3C};
    ev  = '{1'b0, 1'b0, 1'b1, 1'b1};
    ed  = '{8'h00, 8'h00, 8'hA5, 8'h3C};
    pv = 1'b0;
    pd = 8'h00;
    for (int j = 0; j < 4; j++) begin
      cur = sym[j];
      bad = 0;
      for (int i = 7; i >= 1; i--) begin
        send_bit(cur[i]);
        if (valid_out !== pv || data_out !== pd || byte_stb !== 1'b0)
          bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL data_hold%0d: %0d bad cycles want v=%b d=%h",
                 j, bad, pv, pd);
      end
      send_bit(cur[0]);
      checks++;
      if (byte_stb !== 1'b1 || valid_out !== ev[j] || data_out !== ed[j]) begin
        errors++;
        $display("FAIL data_sym%0d: stb=%b v=%b d=%h want 1/%b/%h",
                 j, byte_stb, valid_out, data_out, ev[j], ed[j]);
      end
      pv = ev[j];
      pd = ed[j];
    end
  endtask

  task automatic test_align_fail();
    pulse_reset();
    for (int i = 0; i < 8; i++) send_bit(1'b0);
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h55);
    checks++;
    if (active !== 1'b0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL align_fail: active=%b valid=%b want 0/0",
               active, valid_out);
    end
    lock4("relock");
  endtask

  task automatic test_reset_mid();
    send_byte(8'hA5);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 8'hA5) begin
      errors++;
      $display("FAIL pre_reset: v=%b d=%h want 1/a5", valid_out, data_out);
    end
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge clk);
    data_in = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({data_out, valid_out, byte_stb, active, sync_lost} !== 12'h000) begin
      errors++;
      $display("FAIL async_reset: got %h/%b/%b/%b/%b want all 0",
               data_out, valid_out, byte_stb, active, sync_lost);
    end
    @(negedge clk);
    reset = 1'b1;
    lock4("mid");
  endtask

`ifdef RX_LOS_DETECT_EN
  task automatic test_los();
    for (int i = 0; i < 31; i++) send_byte(8'h11);
    checks++;
    if (active !== 1'b1 || sync_lost !== 1'b0) begin
      errors++;
      $display("FAIL los_31: active=%b lost=%b want 1/0", active, sync_lost);
    end
    send_byte(8'h11);
    checks++;
    if (sync_lost !== 1'b1 || active !== 1'b0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL los_32: lost=%b active=%b v=%b want 1/0/0",
               sync_lost, active, valid_out);
    end
    send_bit(1'b0);
    checks++;
    if (sync_lost !== 1'b0) begin
      errors++;
      $display("FAIL los_pulse: lost=%b want 0", sync_lost);
    end
    pulse_reset();
    lock4("los");
    for (int i = 0; i < 31; i++) send_byte(8'h11);
    send_byte(8'hBC);
    checks++;
    if (active !== 1'b1 || sync_lost !== 1'b0) begin
      errors++;
      $display("FAIL los_com_wins: active=%b lost=%b want 1/0",
               active, sync_lost);
    end
  endtask
`else
  task automatic test_no_los();
    int lost_seen;
    lost_seen = 0;
    for (int i = 0; i < 40; i++) begin
      for (int b = 7; b >= 0; b--) begin
        send_bit(b == 4 || b == 0);
        if (sync_lost) lost_seen++;
      end
    end
    checks++;
    if (lost_seen != 0 || active !== 1'b1) begin
      errors++;
      $display("FAIL no_los: lost=%0d active=%b want 0/1",
               lost_seen, active);
    end
    checks++;
    if (valid_out !== 1'b1 || data_out !== 8'h11) begin
      errors++;
      $display("FAIL no_los_data: v=%b d=%h want 1/11", valid_out, data_out);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lock();
    test_data();
    test_align_fail();
    test_reset_mid();
`ifdef RX_LOS_DETECT_EN
    test_los();
`else
    test_no_los();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel_rx.md
Name: serial_to_parallel_rx

Overview:
- Downstream lane receiver that consumes one serial lane produced by the switch's parallel-to-serial output stage.
- Finds byte alignment on the COM symbol (8'hBC) and locks after BC_LOCK consecutive aligned COMs.
- Once locked, emits deserialized data bytes with a valid flag, discarding COM and IDLE (8'h7C).
- One instance is used per lane (lane 0 and lane 1), clocked on the 8x bit clock.

Parameters:
- DATA_SIZE, 8: width of the deserialized symbol.
- COM, 8'hBC: alignment/comma symbol.
- IDLE, 8'h7C: idle filler symbol, never forwarded.
- BC_LOCK, 4: consecutive aligned COM symbols required to enter ACTIVE. Legal range 1..15.
- LOS_LIMIT, 32: bytes allowed without a COM before sync loss. Used only with the optional feature.

Ports:
- clk  input  1  bit clock (8f). All logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  1  serial bit, MSB of each symbol first.
- data_out  output  DATA_SIZE  last forwarded data byte.
- valid_out  output  1  data_out holds a valid data byte for the current byte period.
- byte_stb  output  1  one-cycle pulse at every byte boundary while not in SEARCH.
- active  output  1  receiver locked (state ACTIVE).
- sync_lost  output  1  one-cycle pulse when ACTIVE is left. Tied 0 without the macro.

Behaviour:
- Reset (reset=0, asynchronous): state=SEARCH, shift register=0, bit_cnt=0, bc_cnt=0, data_out=0, valid_out=0, byte_stb=0, active=0, sync_lost=0. Reset mid-byte discards all partial data.
- Shift register: sr <= {sr[DATA_SIZE-2:0], data_in} every cycle. The candidate symbol is {sr[DATA_SIZE-2:0], data_in}, which includes the current bit.
- Byte boundary: defined as bit_cnt==7 while not in SEARCH. bit_cnt is 3 bits and wraps 7->0.
- SEARCH:
  - Candidate is compared against COM every cycle.
  - On match: bit_cnt<=0, bc_cnt<=1, go to ALIGN. If BC_LOCK==1, go straight to ACTIVE.
  - No outputs change in this state.
- ALIGN, at each byte boundary:
  - Candidate==COM: bc_cnt++. When bc_cnt+1==BC_LOCK, go to ACTIVE and set active<=1.
  - Any other symbol: go to SEARCH and clear bc_cnt.
  - valid_out stays 0.
- ACTIVE, at each byte boundary:
  - COM or IDLE: valid_out<=0 and data_out is held.
  - Any other symbol: data_out<=candidate, valid_out<=1.
  - valid_out and data_out hold until the next boundary, i.e. 8 clocks.
  - ACTIVE is sticky until reset, except as described under the optional feature.
- Latency: the last bit of a symbol sampled on edge t makes data_out/valid_out visible after edge t (registered, 1 cycle).
- byte_stb is asserted in the same cycle data_out updates.
- bc_cnt saturates at BC_LOCK. It is 4 bits wide.

Optional Feature:
- Macro: RX_LOS_DETECT_EN.
- With the macro:
  - A 6-bit los_cnt is cleared at every COM boundary and incremented at every other boundary in ACTIVE.
  - When los_cnt reaches LOS_LIMIT: go to SEARCH, active<=0, valid_out<=0, sync_lost pulses for 1 cycle, bc_cnt<=0.
  - If COM arrives on the same boundary as the limit, COM wins and the receiver stays ACTIVE.
- Without the macro: no los_cnt, sync_lost is constant 0, and ACTIVE leaves only on reset.

Decomposition:
- Shared package/header (`ifndef-guarded include): COM and IDLE symbol constants, and the state encoding SEARCH=2'd0, ALIGN=2'd1, ACTIVE=2'd2.
- The lane-lock FSM (bc_cnt/state/los_cnt) is a natural sub-module: rx_lock_fsm.
  - Inputs: byte boundary, is_com.
  - Outputs: state, active, sync_lost.
- Shift register, bit counter and output registers stay in the top module.

Test Plan:
- Reset held low while data_in toggles -> all outputs 0. Release reset -> state SEARCH, no byte_stb.
- Stream 3 garbage bits, then 4x 8'hBC -> active rises 1 cycle after the last bit of the 4th BC. valid_out stays 0 throughout.
- Locked, then send 8'hBC, 8'h7C, 8'hA5, 8'h3C -> valid_out 0,0,1,1 per byte period. data_out=8'hA5 then 8'h3C, each held 8 cycles. byte_stb pulses every 8 cycles.
- In ALIGN after 2 BCs, send 8'h55 -> return to SEARCH, bc_cnt=0. A further 4 BCs are then required to lock.
- Assert reset in the middle of the 4th bit of 8'hA5 while ACTIVE -> outputs clear immediately (asynchronously). Re-lock needs 4 BCs.
- With RX_LOS_DETECT_EN, lock then send 32 bytes of 8'h11 -> sync_lost pulses once, active=0. Repeat with BC as the 32nd byte -> stays ACTIVE.
